// File: rtl/axi_tb_pkg.sv
// Shared encodings and FSM state types for the AXI4 memory slave
// and its byte-array storage.
package axi_tb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int BEAT_BYTES = 8;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Byte-wide RAM with one 64-bit combinational read port and one byte-strobed
// 64-bit write port; `mem` stays at this level so a bench can preload it.
module axi_mem_array
    import axi_tb_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:3] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic [7:0]    i_wstrb,
    input  logic [AW-1:3] i_raddr,
    output logic [63:0]   o_rdata
);

    logic [7:0] mem [0:(2**AW)-1];

    // Ports carry beat indices; the lane number supplies the low address bits.
    generate
        for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_rd_lane
            assign o_rdata[gi*8 +: 8] = mem[{i_raddr, 3'(gi)}];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (i_wstrb[i]) begin
                    mem[{i_waddr, 3'(i)}] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory model: 64-bit beats over a byte RAM, independent read and
// write FSMs, and a mailbox strobe for writes to MAILBOX_ADDR.
module axi_mem_slave
    import axi_tb_pkg::*;
#(
    parameter int          TAGW         = 1,
    parameter int          MEM_AW       = 16,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD0580000
) (
    input  logic            aclk,
    input  logic            rst_l,

    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [TAGW-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic [2:0]      arsize,

    output logic            rvalid,
    input  logic            rready,
    output logic [63:0]     rdata,
    output logic [1:0]      rresp,
    output logic [TAGW-1:0] rid,
    output logic            rlast,

    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     awaddr,
    input  logic [TAGW-1:0] awid,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic [2:0]      awsize,

    input  logic [63:0]     wdata,
    input  logic [7:0]      wstrb,
    input  logic            wvalid,
    output logic            wready,

    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [TAGW-1:0] bid,

    output logic            mailbox_write,
    output logic [63:0]     WriteData
);

    rd_state_t       r_rd_state, w_rd_state_next;
    logic [31:0]     r_rd_addr;
    logic [TAGW-1:0] r_rd_id;
    logic [7:0]      r_rd_len, r_rd_cnt;

    wr_state_t       r_wr_state, w_wr_state_next;
    logic [31:0]     r_wr_addr;
    logic [TAGW-1:0] r_wr_id;
    logic [7:0]      r_wr_len, r_wr_cnt;

    logic            w_rd_last, w_wr_last, w_wr_beat, w_mbox_hit, w_mem_we;
    logic [63:0]     w_mem_rdata;

    // Size and burst type are ignored: every burst walks aligned 8-byte beats.
    logic w_unused;
    assign w_unused = ^{arsize, awsize, arburst, awburst, araddr[2:0], awaddr[2:0]};

    assign w_rd_last  = (r_rd_cnt == r_rd_len);
    assign w_wr_last  = (r_wr_cnt == r_wr_len);
    assign w_wr_beat  = (r_wr_state == W_DATA) && wvalid;
    assign w_mbox_hit = (r_wr_addr == MAILBOX_ADDR);
    assign w_mem_we   = !rst_l && w_wr_beat && !w_mbox_hit;

    assign mailbox_write = !rst_l && w_wr_beat && w_mbox_hit;
    assign WriteData     = wdata;
    assign rresp         = RESP_OKAY;
    assign bresp         = RESP_OKAY;

    axi_mem_array #(.AW(MEM_AW)) u_array (
        .clk     (aclk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_addr[MEM_AW-1:3]),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_raddr (r_rd_addr[MEM_AW-1:3]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge aclk) begin
        if (rst_l) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_id    <= '0;
            r_rd_len   <= '0;
            r_rd_cnt   <= '0;
            r_wr_state <= W_IDLE;
            r_wr_addr  <= '0;
            r_wr_id    <= '0;
            r_wr_len   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_rd_state <= w_rd_state_next;
            r_wr_state <= w_wr_state_next;

            if (r_rd_state == R_IDLE && arvalid) begin
                r_rd_addr <= {araddr[31:3], 3'b000};
                r_rd_id   <= arid;
                r_rd_len  <= arlen;
                r_rd_cnt  <= '0;
            end else if (r_rd_state == R_DATA && rready) begin
                r_rd_addr <= r_rd_addr + 32'd8;
                r_rd_cnt  <= r_rd_cnt + 8'd1;
            end

            if (r_wr_state == W_IDLE && awvalid) begin
                r_wr_addr <= {awaddr[31:3], 3'b000};
                r_wr_id   <= awid;
                r_wr_len  <= awlen;
                r_wr_cnt  <= '0;
            end else if (w_wr_beat) begin
                r_wr_addr <= r_wr_addr + 32'd8;
                r_wr_cnt  <= r_wr_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        arready         = 1'b0;
        rvalid          = 1'b0;
        rlast           = 1'b0;
        rid             = '0;
        rdata           = '0;
        unique case (r_rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rd_state_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rid    = r_rd_id;
                rdata  = w_mem_rdata;
                rlast  = w_rd_last;
                if (rready && w_rd_last) w_rd_state_next = R_IDLE;
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        awready         = 1'b0;
        wready          = 1'b0;
        bvalid          = 1'b0;
        bid             = '0;
        unique case (r_wr_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_wr_state_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_wr_last) w_wr_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = r_wr_id;
                if (bready) w_wr_state_next = W_IDLE;
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: inputs change and outputs are sampled on
// the falling edge, so each check sees the state settled after a rising edge.
module tb_axi_mem_slave;
    import axi_tb_pkg::*;

    logic        aclk = 1'b0;
    logic        rst_l;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [0:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic        rvalid, rready, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [0:0]  rid;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [0:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [0:0]  bid;
    logic        mailbox_write;
    logic [63:0] WriteData;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 aclk = ~aclk;

    axi_mem_slave #(.TAGW(1), .MEM_AW(16), .MAILBOX_ADDR(32'hD0580000)) dut (
        .aclk(aclk), .rst_l(rst_l),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arburst(arburst), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awburst(awburst), .awsize(awsize),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .mailbox_write(mailbox_write), .WriteData(WriteData)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [0:0] id, input logic [7:0] len);
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len;
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [0:0] id, input logic [7:0] len);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len;
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Each byte holds its own low address byte, except the 0x100 test pattern.
        for (int i = 0; i < 65536; i++) dut.u_array.mem[i] = i[7:0];
        for (int k = 0; k < 8; k++) dut.u_array.mem[32'h100 + k] = 8'(k + 1);

        rst_l = 1'b1;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = BURST_INCR; arsize = 3'd3;
        rready = 0;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = BURST_INCR; awsize = 3'd3;
        wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        repeat (2) @(negedge aclk);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_mailbox", 64'(mailbox_write), 64'd0);
        rst_l = 1'b0;
        @(negedge aclk);

        // Single-beat read of the preloaded pattern
        rready = 1'b1;
        send_ar(32'h100, 1'b1, 8'd0);
        check("rd1_rvalid", 64'(rvalid), 64'd1);
        check("rd1_rdata", rdata, 64'h0807060504030201);
        check("rd1_rlast", 64'(rlast), 64'd1);
        check("rd1_rid", 64'(rid), 64'd1);
        check("rd1_rresp", 64'(rresp), 64'd0);
        check("rd1_arready", 64'(arready), 64'd0);
        @(negedge aclk);
        check("rd1_done", 64'(rvalid), 64'd0);
        $display("txn read addr=100 len=0 done");

        // Partial-strobe write, then held B response
        send_aw(32'h200, 1'b1, 8'd0);
        check("wr1_wready", 64'(wready), 64'd1);
        check("wr1_awready", 64'(awready), 64'd0);
        wvalid = 1'b1; wdata = 64'h1122334455667788; wstrb = 8'h0F;
        #1 check("wr1_writedata", WriteData, 64'h1122334455667788);
        check("wr1_nombox", 64'(mailbox_write), 64'd0);
        @(negedge aclk);
        wvalid = 1'b0;
        check("wr1_bvalid", 64'(bvalid), 64'd1);
        check("wr1_bid", 64'(bid), 64'd1);
        check("wr1_bresp", 64'(bresp), 64'd0);
        @(negedge aclk);
        check("wr1_bhold", 64'(bvalid), 64'd1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("wr1_bdone", 64'(bvalid), 64'd0);
        check("wr1_awready_back", 64'(awready), 64'd1);
        send_ar(32'h200, 1'b0, 8'd0);
        check("wr1_readback", rdata, 64'h0706050455667788);
        @(negedge aclk);
        $display("txn write addr=200 strb=0f done");

        // Four-beat read with a two-cycle stall on beat 1
        send_ar(32'h0, 1'b0, 8'd3);
        check("rd4_b0", rdata, 64'h0706050403020100);
        check("rd4_b0_last", 64'(rlast), 64'd0);
        @(negedge aclk);
        check("rd4_b1", rdata, 64'h0f0e0d0c0b0a0908);
        rready = 1'b0;
        @(negedge aclk);
        check("rd4_stall1", rdata, 64'h0f0e0d0c0b0a0908);
        @(negedge aclk);
        check("rd4_stall2", rdata, 64'h0f0e0d0c0b0a0908);
        check("rd4_stall_valid", 64'(rvalid), 64'd1);
        check("rd4_stall_last", 64'(rlast), 64'd0);
        rready = 1'b1;
        @(negedge aclk);
        check("rd4_b2", rdata, 64'h1716151413121110);
        check("rd4_b2_last", 64'(rlast), 64'd0);
        @(negedge aclk);
        check("rd4_b3", rdata, 64'h1f1e1d1c1b1a1918);
        check("rd4_b3_last", 64'(rlast), 64'd1);
        @(negedge aclk);
        check("rd4_done", 64'(rvalid), 64'd0);
        $display("txn read addr=0 len=3 with stall done");

        // Mailbox write: strobe for one cycle, memory (alias of 0x0) untouched
        send_aw(32'hD0580000, 1'b0, 8'd0);
        check("mb_pre", 64'(mailbox_write), 64'd0);
        wvalid = 1'b1; wdata = 64'h41; wstrb = 8'hFF;
        #1 check("mb_pulse", 64'(mailbox_write), 64'd1);
        check("mb_writedata", WriteData, 64'h41);
        @(negedge aclk);
        wvalid = 1'b0;
        check("mb_post", 64'(mailbox_write), 64'd0);
        check("mb_bvalid", 64'(bvalid), 64'd1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("mb_bdone", 64'(bvalid), 64'd0);
        send_ar(32'h0, 1'b0, 8'd0);
        check("mb_mem_unchanged", rdata, 64'h0706050403020100);
        @(negedge aclk);
        $display("txn mailbox write 41 done");

        // Reset during the second beat of a four-beat read
        send_ar(32'h40, 1'b1, 8'd3);
        check("rr_b0", rdata, 64'h4746454443424140);
        @(negedge aclk);
        check("rr_b1", rdata, 64'h4f4e4d4c4b4a4948);
        rst_l = 1'b1;
        @(negedge aclk);
        check("rr_rvalid", 64'(rvalid), 64'd0);
        check("rr_arready", 64'(arready), 64'd1);
        rst_l = 1'b0;
        send_ar(32'h108, 1'b1, 8'd0);
        check("rr_new_rdata", rdata, 64'h0f0e0d0c0b0a0908);
        check("rr_new_rid", 64'(rid), 64'd1);
        @(negedge aclk);
        $display("txn reset mid-burst then read addr=108 done");

        // Concurrent read of 0x300..0x30f and write of 0x308
        arvalid = 1'b1; araddr = 32'h300; arid = 1'b0; arlen = 8'd1;
        awvalid = 1'b1; awaddr = 32'h308; awid = 1'b1; awlen = 8'd0;
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        check("cc_rd_b0", rdata, 64'h0706050403020100);
        check("cc_wready", 64'(wready), 64'd1);
        @(negedge aclk);
        rready = 1'b0;
        wvalid = 1'b1; wdata = 64'hDEADBEEFCAFEF00D; wstrb = 8'hFF;
        #1 check("cc_same_cycle_old", rdata, 64'h0f0e0d0c0b0a0908);
        @(negedge aclk);
        wvalid = 1'b0;
        check("cc_later_new", rdata, 64'hDEADBEEFCAFEF00D);
        check("cc_rlast", 64'(rlast), 64'd1);
        check("cc_bvalid", 64'(bvalid), 64'd1);
        check("cc_bid", 64'(bid), 64'd1);
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("cc_rdone", 64'(rvalid), 64'd0);
        check("cc_bdone", 64'(bvalid), 64'd0);
        $display("txn concurrent read 300 / write 308 done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave memory model for the SweRV testbench fabric: a 64-bit data, byte-addressed RAM behind full AR/R/AW/W/B channels.
- Two instances sit behind the address decoder: one for the low region, one for the high region. Both are preloaded from the program image through the hierarchical array `mem`.
- Also flags writes to the simulation mailbox so the bench can print characters and detect test end.

Parameters:
- TAGW, 1, width of arid/rid/awid/bid.
- MEM_AW, 16, byte-address bits decoded into `mem`; depth is 2**MEM_AW bytes; higher address bits alias.
- MAILBOX_ADDR, 32'hD0580000, byte address of the mailbox register.

Ports:
- aclk in 1: clock; all logic on the rising edge.
- rst_l in 1: reset; synchronous, active-high (1 = reset).
- arvalid in 1 / arready out 1 / araddr in 32 / arid in TAGW / arlen in 8 / arburst in 2 / arsize in 3: read address channel.
- rvalid out 1 / rready in 1 / rdata out 64 / rresp out 2 / rid out TAGW / rlast out 1: read data channel.
- awvalid in 1 / awready out 1 / awaddr in 32 / awid in TAGW / awlen in 8 / awburst in 2 / awsize in 3: write address channel.
- wdata in 64 / wstrb in 8 / wvalid in 1 / wready out 1: write data channel.
- bvalid out 1 / bready in 1 / bresp out 2 / bid out TAGW: write response channel.
- mailbox_write out 1: pulses for an accepted write beat to MAILBOX_ADDR.
- WriteData out 64: equals wdata, combinational.

Behaviour:
- Storage: `mem` is a byte array [0 : 2**MEM_AW-1]. It is not cleared by reset and is loadable by $readmemh.
- Beat address: each beat covers 8 bytes at (base & ~7) + 8*n, indexed modulo 2**MEM_AW. arsize and awsize are ignored. FIXED and WRAP bursts are treated as INCR. rresp and bresp are always 2'b00 (OKAY).
- Reset values: arready=1, rvalid=0, rlast=0, rid=0, rdata=0, awready=1, wready=0, bvalid=0, bid=0, mailbox_write=0.
- Read FSM, state R_IDLE:
  - arready=1.
  - On arvalid, latch address, id and len (beat count = arlen+1), reset the beat counter, and go to R_DATA.
- Read FSM, state R_DATA:
  - arready=0, rvalid=1, rid = latched id.
  - rdata = {mem[a+7] … mem[a]} for the current beat address a, read combinationally from the array.
  - rlast=1 on the final beat.
  - On rready, advance the beat. On the final beat, return to R_IDLE.
  - First beat is valid the cycle after the AR handshake. Beats hold stable while rready=0. Back-to-back bursts have one idle cycle between them.
- Write FSM, state W_IDLE:
  - awready=1, wready=0.
  - On awvalid, latch address, id and len, and go to W_DATA.
  - W beats arriving before AW are not accepted.
- Write FSM, state W_DATA:
  - wready=1.
  - Each wvalid beat writes byte lane i to mem[a+i] when wstrb[i]=1, at that clock edge.
  - After awlen+1 beats, go to W_RESP. wlast is not required; the beat counter is authoritative.
- Write FSM, state W_RESP:
  - bvalid=1, bid = latched id.
  - On bready, return to W_IDLE.
- Mailbox:
  - mailbox_write = rst_l==0 && state W_DATA && wvalid && latched beat address == MAILBOX_ADDR.
  - Mailbox beats are not stored into `mem`. They still complete the handshake normally with a B response.
- Read and write FSMs are independent and may run concurrently.
  - A write beat and a read beat to the same address in the same cycle: the read returns the old data (combinational read before the edge).
  - A read in any later cycle sees the new data.
- Reset mid-burst: both FSMs return to idle, all outputs take reset values, and the partial transaction is abandoned. Bytes already written are retained.

Decomposition:
- Shared package `axi_tb_pkg`:
  - RESP_OKAY constant.
  - BURST_FIXED/INCR/WRAP encodings.
  - Read FSM enum (R_IDLE, R_DATA) and write FSM enum (W_IDLE, W_DATA, W_RESP).
  - Beat width constant (8 bytes).
- One natural sub-module, `axi_mem_array`:
  - Byte RAM with a 64-bit combinational read port and a byte-strobed 64-bit write port.
  - Keeps the array named `mem` at a known hierarchical path for preload.

Test Plan:
- Preload mem[0x100..0x107] = 01..08. AR addr=0x100, len=0, rready=1 → one cycle later rvalid=1, rdata=64'h0807060504030201, rlast=1, rid=arid, rresp=0.
- AW addr=0x200, len=0, id=1, then W wdata=64'h1122334455667788, wstrb=8'h0F → mem[0x200..0x203] = 88,77,66,55; upper four bytes unchanged; bvalid=1 with bid=1 until bready.
- AR addr=0x0, len=3, with rready low for 2 cycles on beat 1 → 4 beats at 0x0/0x8/0x10/0x18; rdata stable while stalled; rlast only on beat 3.
- AW addr=0xD0580000, W wdata=64'h41 → mailbox_write pulses exactly 1 cycle, WriteData=64'h41; mem unchanged; B response returned.
- Assert rst_l=1 during read beat 2 of 4 → next cycle rvalid=0, arready=1; a new AR is then served correctly.
- Concurrent AR to 0x300 and AW/W to 0x308 → both complete independently; read data is the pre-write contents.
